// File: rtl/ifetch_window_pkg.sv
// Shared constants and types for the instruction prefetch window.
package ifetch_window_pkg;

    localparam int unsigned INST_BYTES = 10;
    localparam int unsigned WORD_BYTES = 8;
    localparam int unsigned WIN_WORDS  = 3;
    localparam int unsigned WIN_BYTES  = WIN_WORDS * WORD_BYTES;
    localparam int unsigned WORD_W     = WORD_BYTES * 8;
    localparam int unsigned INST_W     = INST_BYTES * 8;
    localparam int unsigned CNT_W      = 2;

    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_FILL = 2'd1,
        FS_ERR  = 2'd2
    } fstate_e;

    // word[0] occupies the low bits, so the flat vector is little-endian by byte
    typedef logic [WIN_WORDS-1:0][WORD_W-1:0] window_t;

endpackage

// File: rtl/fetch_window_extract.sv
// Combinational hit/overflow detection and 10-byte extraction from the window.
module fetch_window_extract
    import ifetch_window_pkg::*;
#(
    parameter int unsigned ADDR_W = 64
) (
    input  logic [ADDR_W-1:0] base,
    input  window_t           words,
    input  logic              valid,
    input  logic [ADDR_W-1:0] pc,
    output logic              hit,
    output logic              overflow,
    output logic [INST_W-1:0] inst
);

    localparam int unsigned       OFF_W     = 4;
    localparam logic [ADDR_W-1:0] MAX_OFF   = ADDR_W'(WIN_BYTES - INST_BYTES);
    localparam logic [ADDR_W-1:0] OVF_LIMIT = {ADDR_W{1'b1}} - ADDR_W'(INST_BYTES - 1);

    logic [ADDR_W-1:0]      offset;
    logic [OFF_W-1:0]       sel;
    logic [WIN_BYTES*8-1:0] flat;
    logic [INST_W-1:0]      shifted;

    // pc+9 <= base+23 is evaluated as (pc-base) <= 14 once pc >= base holds
    always_comb begin
        offset   = pc - base;
        overflow = pc > OVF_LIMIT;
        hit      = valid && !overflow && (pc >= base) && (offset <= MAX_OFF);
        sel      = offset[OFF_W-1:0];
        flat     = words;
        shifted  = INST_W'(flat >> {sel, 3'b000});
        inst     = '0;
        if (hit) begin
            for (int k = 0; k < int'(INST_BYTES); k++) begin
                inst[INST_W-1-8*k -: 8] = shifted[8*k +: 8];
            end
        end
    end

endmodule

// File: rtl/ifetch_window.sv
// Instruction-side responder: 3-word prefetch window filled over a req/ack word bus.
module ifetch_window
    import ifetch_window_pkg::*;
#(
    parameter int unsigned ADDR_W = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              inv_i,
    output logic [INST_W-1:0] inst_o,
    output logic              i_mem_error_o,
    output logic              stall_o,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_ack_i,
    input  logic [WORD_W-1:0] mem_rdata_i,
    input  logic              mem_err_i
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(WORD_BYTES - 1);

    fstate_e           state_q;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] fbase_q;
    logic [ADDR_W-1:0] err_pc_q;
    window_t           words_q;
    logic              valid_q;
    logic              discard_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              hit_c;
    logic              overflow_c;
    logic [INST_W-1:0] inst_c;

    fetch_window_extract #(
        .ADDR_W (ADDR_W)
    ) u_extract (
        .base     (base_q),
        .words    (words_q),
        .valid    (valid_q),
        .pc       (pc_i),
        .hit      (hit_c),
        .overflow (overflow_c),
        .inst     (inst_c)
    );

    // Fill FSM: a fill always runs to completion; pc changes are re-checked afterwards
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= FS_IDLE;
            base_q     <= '0;
            fbase_q    <= '0;
            err_pc_q   <= '0;
            words_q    <= '0;
            valid_q    <= 1'b0;
            discard_q  <= 1'b0;
            cnt_q      <= '0;
            mem_req_o  <= 1'b0;
            mem_addr_o <= '0;
        end else begin
            case (state_q)
                FS_IDLE: begin
                    if (!hit_c && !overflow_c) begin
                        fbase_q    <= pc_i & ALIGN_MASK;
                        mem_addr_o <= pc_i & ALIGN_MASK;
                        mem_req_o  <= 1'b1;
                        cnt_q      <= '0;
                        valid_q    <= 1'b0;
                        discard_q  <= 1'b0;
                        state_q    <= FS_FILL;
                    end else if (inv_i) begin
                        valid_q <= 1'b0;
                    end
                end
                FS_FILL: begin
                    if (inv_i) begin
                        discard_q <= 1'b1;
                    end
                    if (mem_ack_i) begin
                        if (mem_err_i) begin
                            err_pc_q  <= pc_i;
                            valid_q   <= 1'b0;
                            mem_req_o <= 1'b0;
                            state_q   <= FS_ERR;
                        end else begin
                            words_q[cnt_q] <= mem_rdata_i;
                            if (cnt_q == CNT_W'(WIN_WORDS - 1)) begin
                                // an invalidate on the final edge also counts
                                base_q    <= fbase_q;
                                valid_q   <= !(discard_q || inv_i);
                                mem_req_o <= 1'b0;
                                cnt_q     <= '0;
                                state_q   <= FS_IDLE;
                            end else begin
                                cnt_q      <= cnt_q + CNT_W'(1);
                                mem_addr_o <= mem_addr_o + ADDR_W'(WORD_BYTES);
                            end
                        end
                    end
                end
                FS_ERR: begin
                    if (pc_i != err_pc_q) begin
                        state_q <= FS_IDLE;
                    end
                end
                default: begin
                    state_q <= FS_IDLE;
                end
            endcase
        end
    end

    // Fetch-facing outputs follow pc_i within the same cycle
    always_comb begin
        stall_o       = !hit_c && !overflow_c && (state_q != FS_ERR);
        i_mem_error_o = overflow_c || ((state_q == FS_ERR) && (pc_i == err_pc_q));
        inst_o        = hit_c ? inst_c : '0;
    end

endmodule

// File: tb/tb_ifetch_window.sv
// Scoreboard bench for ifetch_window: expected fetch results and bus addresses are queued by stimulus.
module tb_ifetch_window;
    import ifetch_window_pkg::*;

    localparam int unsigned AW = 64;

    logic              clk = 1'b0;
    logic              rst_i;
    logic [AW-1:0]     pc_i;
    logic              inv_i;
    logic [INST_W-1:0] inst_o;
    logic              i_mem_error_o;
    logic              stall_o;
    logic              mem_req_o;
    logic [AW-1:0]     mem_addr_o;
    logic              mem_ack_i;
    logic [WORD_W-1:0] mem_rdata_i;
    logic              mem_err_i;

    ifetch_window #(.ADDR_W(AW)) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .pc_i          (pc_i),
        .inv_i         (inv_i),
        .inst_o        (inst_o),
        .i_mem_error_o (i_mem_error_o),
        .stall_o       (stall_o),
        .mem_req_o     (mem_req_o),
        .mem_addr_o    (mem_addr_o),
        .mem_ack_i     (mem_ack_i),
        .mem_rdata_i   (mem_rdata_i),
        .mem_err_i     (mem_err_i)
    );

    initial forever #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [INST_W-1:0] inst;
        logic              err;
        int unsigned       due;
        string             name;
    } exp_t;

    exp_t          exp_q[$];
    logic [AW-1:0] addr_q[$];
    int            errors = 0;
    int            checks = 0;
    int unsigned   waits = 0;
    logic [AW-1:0] err_addr = '1;

    localparam logic [INST_W-1:0] INST_0    = 80'h30F60200000000000000;
    localparam logic [INST_W-1:0] INST_14   = 80'h00001011121314151617;
    localparam logic [INST_W-1:0] INST_10   = 80'h00000000000010111213;
    localparam logic [INST_W-1:0] INST_15   = 80'h00101112131415161718;
    localparam logic [INST_W-1:0] INST_107  = 80'h0708090A0B0C0D0E0F10;
    localparam logic [INST_W-1:0] INST_X00  = 80'h00010203040506070809;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] mem_byte(input logic [AW-1:0] a);
        if (a == 64'd0)      return 8'h30;
        else if (a == 64'd1) return 8'hF6;
        else if (a == 64'd2) return 8'h02;
        else if (a < 64'd16) return 8'h00;
        else                 return a[7:0];
    endfunction

    function automatic logic [WORD_W-1:0] mem_word(input logic [AW-1:0] a);
        logic [WORD_W-1:0] w;
        for (int j = 0; j < 8; j++) w[8*j +: 8] = mem_byte(a + AW'(j));
        return w;
    endfunction

    // Backing memory: acks after `waits` idle cycles of a held request
    initial begin
        int unsigned wcnt;
        wcnt = 0;
        mem_ack_i = 1'b0;
        mem_rdata_i = '0;
        mem_err_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_req_o) begin
                if (wcnt >= waits) begin
                    mem_ack_i   = 1'b1;
                    mem_rdata_i = mem_word(mem_addr_o);
                    mem_err_i   = (mem_addr_o == err_addr);
                    wcnt        = 0;
                end else begin
                    mem_ack_i = 1'b0;
                    mem_err_i = 1'b0;
                    wcnt++;
                end
            end else begin
                mem_ack_i = 1'b0;
                mem_err_i = 1'b0;
                wcnt      = 0;
            end
        end
    end

    // Monitor: accepted requests and unstalled fetch results
    exp_t          mon_e;
    logic [AW-1:0] mon_a;
    initial forever begin
        @(negedge clk);
        if (!rst_i) begin
            if (mem_req_o && mem_ack_i) begin
                if (addr_q.size() == 0) begin
                    chk("unexpected_req", 128'(mem_addr_o), 128'(64'hDEAD));
                end else begin
                    mon_a = addr_q.pop_front();
                    chk("req_addr", 128'(mem_addr_o), 128'(mon_a));
                end
            end
            if (!stall_o && exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                chk({mon_e.name, "_inst"}, 128'(inst_o), 128'(mon_e.inst));
                chk({mon_e.name, "_err"}, 128'(i_mem_error_o), 128'(mon_e.err));
                chk({mon_e.name, "_cycle"}, 128'(cyc), 128'(mon_e.due));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic expect_at(input string name, input logic [INST_W-1:0] inst,
                             input logic err, input int unsigned lat);
        exp_t e;
        e.inst = inst;
        e.err  = err;
        e.due  = cyc + lat;
        e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic push_fill(input logic [AW-1:0] b);
        addr_q.push_back(b);
        addr_q.push_back(b + 64'd8);
        addr_q.push_back(b + 64'd16);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            step();
            n++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: %0d results still pending, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic fetch(input string name, input logic [AW-1:0] pc,
                         input logic [INST_W-1:0] inst, input logic err, input int unsigned lat);
        pc_i = pc;
        expect_at(name, inst, err, lat);
        drain(name);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1;
        pc_i  = '0;
        inv_i = 1'b0;
        repeat (3) step();
        chk("rst_stall", 128'(stall_o), 128'(1'b1));
        chk("rst_req", 128'(mem_req_o), 128'(1'b0));
        chk("rst_addr", 128'(mem_addr_o), 128'(0));
        chk("rst_err", 128'(i_mem_error_o), 128'(1'b0));
        chk("rst_inst", 128'(inst_o), 128'(0));

        // Cold miss at 0, zero-wait: 4-cycle penalty
        rst_i = 1'b0;
        push_fill(64'd0);
        fetch("cold0", 64'd0, INST_0, 1'b0, 4);
        fetch("hit14", 64'd14, INST_14, 1'b0, 0);
        fetch("hit10", 64'd10, INST_10, 1'b0, 0);
        push_fill(64'd8);
        fetch("miss15", 64'd15, INST_15, 1'b0, 4);

        // Two wait states per word
        waits = 2;
        push_fill(64'h100);
        fetch("wait107", 64'h107, INST_107, 1'b0, 10);
        waits = 0;

        // Bus error on second word, held pc, then recovery
        err_addr = 64'h208;
        addr_q.push_back(64'h200);
        addr_q.push_back(64'h208);
        fetch("buserr", 64'h200, '0, 1'b1, 3);
        fetch("buserr_hold", 64'h200, '0, 1'b1, 0);
        err_addr = '1;
        push_fill(64'h300);
        pc_i = 64'h300;
        expect_at("err_exit", '0, 1'b0, 0);
        expect_at("refill300", INST_X00, 1'b0, 5);
        drain("refill300");

        // Address overflow: immediate error, no bus traffic
        fetch("ovf", 64'hFFFF_FFFF_FFFF_FFF8, '0, 1'b1, 0);
        fetch("ovf_hold1", 64'hFFFF_FFFF_FFFF_FFF8, '0, 1'b1, 0);
        fetch("ovf_hold2", 64'hFFFF_FFFF_FFFF_FFF8, '0, 1'b1, 0);

        // Reset in the middle of a waited fill
        waits = 2;
        pc_i = 64'h400;
        step();
        step();
        rst_i = 1'b1;
        step();
        chk("midrst_req", 128'(mem_req_o), 128'(1'b0));
        chk("midrst_stall", 128'(stall_o), 128'(1'b1));
        rst_i = 1'b0;
        push_fill(64'h400);
        expect_at("after_rst400", INST_X00, 1'b0, 10);
        drain("after_rst400");
        waits = 0;

        // Invalidate during fill: same base is fetched twice
        pc_i = 64'h500;
        push_fill(64'h500);
        push_fill(64'h500);
        expect_at("inv_fill500", INST_X00, 1'b0, 8);
        step();
        inv_i = 1'b1;
        step();
        inv_i = 1'b0;
        drain("inv_fill500");

        // Invalidate coinciding with the final ack
        pc_i = 64'h600;
        push_fill(64'h600);
        push_fill(64'h600);
        expect_at("inv_last600", INST_X00, 1'b0, 8);
        step();
        step();
        step();
        inv_i = 1'b1;
        step();
        inv_i = 1'b0;
        drain("inv_last600");

        // Invalidate while idle on a hit: hit this cycle, refetch after
        inv_i = 1'b1;
        push_fill(64'h600);
        expect_at("inv_idle_hit", INST_X00, 1'b0, 0);
        expect_at("inv_idle_refill", INST_X00, 1'b0, 5);
        step();
        inv_i = 1'b0;
        drain("inv_idle");

        repeat (3) step();
        chk("addr_q_empty", 128'(addr_q.size()), 128'(0));
        chk("exp_q_empty", 128'(exp_q.size()), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
